// File: rtl/cla_nibble_serial_adder_if.sv
// rtl/cla_nibble_serial_adder_if.sv - operand/result handshake bundle for the nibble-serial adder
interface cla_nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/cla_nibble_serial_adder.sv
// rtl/cla_nibble_serial_adder.sv - digit-serial adder pushing one nibble per clock through a 4-bit CLA
module cla (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] Sum,
  output logic       Cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = A & B;
  assign p = A ^ B;

  // Every carry is flattened to generate/propagate terms, so none waits on a lower carry.
  assign c[0] = Cin;
  assign c[1] = g[0] | (p[0] & Cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & Cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & Cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & Cin);

  assign Sum  = p ^ c[3:0];
  assign Cout = c[4];
endmodule

module cla_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  cla_nibble_serial_adder_if.slave      bus
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [IDX_W-1:0] idx_q;

  logic [3:0] nib_a;
  logic [3:0] nib_b;
  logic [3:0] nib_sum;
  logic       nib_cout;

  assign nib_a = a_q[4*idx_q +: 4];
  assign nib_b = b_q[4*idx_q +: 4];

  cla u_cla (
    .A    (nib_a),
    .B    (nib_b),
    .Cin  (carry_q),
    .Sum  (nib_sum),
    .Cout (nib_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            idx_q   <= '0;
          end
        end
        RUN: begin
          sum_q[4*idx_q +: 4] <= nib_sum;
          carry_q             <= nib_cout;
          idx_q               <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            cout_q <= nib_cout;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decode state only, so neither valid nor ready sees the other side combinationally.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == RUN) || (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// tb/tb_cla_nibble_serial_adder.sv - directed bench with a transaction-level reference model
module tb_cla_nibble_serial_adder;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n  = 1'b1;
  int   checks = 0;
  int   passed = 0;
  int   cyc    = 0;

  cla_nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  cla_nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
  endtask

  // Reference model: a transaction is pending from acceptance until its result is taken.
  bit          pending  = 1'b0;
  int          acc_cyc  = 0;
  logic [16:0] exp_res  = '0;
  logic [16:0] last_res = '0;

  always @(negedge clk) begin
    bit ov;
    if (!rst_n) begin
      pending  = 1'b0;
      last_res = '0;
    end
    ov = pending && ((cyc - acc_cyc) >= NIB);
    check("cmp_busy", bus.busy, pending);
    check("cmp_in_ready", bus.in_ready, !pending);
    check("cmp_out_valid", bus.out_valid, ov);
    if (ov) begin
      check("cmp_sum", bus.sum, exp_res[15:0]);
      check("cmp_cout", bus.cout, exp_res[16]);
    end else if (!pending) begin
      check("cmp_idle_sum", bus.sum, last_res[15:0]);
      check("cmp_idle_cout", bus.cout, last_res[16]);
    end
    if (rst_n) begin
      if (!pending && bus.in_valid) begin
        pending = 1'b1;
        acc_cyc = cyc + 1;
        exp_res = {1'b0, bus.a} + {1'b0, bus.b} + {16'd0, bus.cin};
      end else if (ov && bus.out_ready) begin
        pending  = 1'b0;
        last_res = exp_res;
      end
    end
  end

  task automatic accept(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    bus.in_valid = 1'b1;
    bus.a = av;
    bus.b = bv;
    bus.cin = cv;
    @(negedge clk);
    check("accept_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit wiggle, output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (wiggle) begin
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
        bus.cin = 1'($urandom);
      end
    end
    check("latency", lat, NIB);
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("take_in_ready", bus.in_ready, 1);
  endtask

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                        input logic [15:0] es, input logic ec);
    int lat;
    accept(av, bv, cv);
    wait_done(1'b0, lat);
    check("lit_sum", bus.sum, es);
    check("lit_cout", bus.cout, ec);
    take();
  endtask

  initial begin
    int lat;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.out_ready = 1'b0;

    #7;
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_sum", bus.sum, 16'h0000);
    check("rst_cout", bus.cout, 0);
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic add with the consumer always ready.
    bus.out_ready = 1'b1;
    accept(16'h1234, 16'h4321, 1'b0);
    wait_done(1'b0, lat);
    check("basic_sum", bus.sum, 16'h5555);
    check("basic_cout", bus.cout, 0);
    @(posedge clk);
    #1;
    check("basic_back_idle", bus.in_ready, 1);
    check("basic_valid_drop", bus.out_valid, 0);
    bus.out_ready = 1'b0;

    run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run_op(16'hD5B3, 16'h2A4C, 1'b1, 16'h0000, 1'b1);

    // Back-pressure with an ignored operand pulse.
    accept(16'h7F0F, 16'h0101, 1'b0);
    wait_done(1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        bus.in_valid = 1'b1;
        bus.a = 16'hAAAA;
        bus.b = 16'h5555;
        bus.cin = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check("bp_sum", bus.sum, 16'h8010);
      check("bp_cout", bus.cout, 0);
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_out_valid", bus.out_valid, 1);
    end
    bus.in_valid = 1'b0;
    take();
    run_op(16'h1111, 16'h2222, 1'b1, 16'h3334, 1'b0);

    // Operand isolation: inputs churn throughout RUN.
    accept(16'h00FF, 16'h0001, 1'b0);
    wait_done(1'b1, lat);
    check("iso_sum", bus.sum, 16'h0100);
    check("iso_cout", bus.cout, 0);
    take();

    // Reset on the second RUN cycle.
    accept(16'h1234, 16'h1111, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", bus.out_valid, 0);
    check("mrst_in_ready", bus.in_ready, 1);
    check("mrst_busy", bus.busy, 0);
    check("mrst_sum", bus.sum, 16'h0000);
    check("mrst_cout", bus.cout, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
      check("mrst_no_valid", bus.out_valid, 0);
    end
    run_op(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/cla_nibble_serial_adder.md
# cla_nibble_serial_adder

Digit-serial WIDTH-bit adder built around the team's 4-bit `CLA` block (ports `A`, `B`, `Cin`, `Sum`, `Cout`). It accepts a pair of operands and a carry-in over a valid/ready handshake. It feeds the CLA one nibble per clock, least-significant nibble first, and registers each `Sum` nibble and `Cout` back as the next carry. It then presents the full sum and final carry over a second valid/ready handshake. The block sits directly around the CLA: it is both the stage that drives its inputs and the stage that consumes its outputs.

## Interface
- `WIDTH`, default 16: operand width in bits; must be a multiple of 4 and at least 8.
- `NIBBLES`, derived as WIDTH/4 (localparam, not overridable): number of CLA passes.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  operand set presented.
- `in_ready`  out  1  block can accept operands.
- `a`  in  WIDTH  operand A; sampled only on acceptance.
- `b`  in  WIDTH  operand B; sampled only on acceptance.
- `cin`  in  1  carry-in; sampled only on acceptance.
- `out_valid`  out  1  `sum` and `cout` are valid.
- `out_ready`  in  1  consumer takes the result.
- `sum`  out  WIDTH  (a + b + cin) mod 2^WIDTH.
- `cout`  out  1  carry out of bit WIDTH-1.
- `busy`  out  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch `a`, `b` into operand registers and `cin` into the carry register, clear the nibble index, go to RUN.
- **RUN**
  - CLA inputs: `A` = a_reg[4*idx+3:4*idx], `B` = b_reg[4*idx+3:4*idx], `Cin` = carry register.
  - Each edge: sum_reg[4*idx+3:4*idx] <= CLA `Sum`; carry <= CLA `Cout`; idx <= idx+1.
  - On the edge processing idx = NIBBLES-1: set `cout` to CLA `Cout` and go to DONE.
- **DONE**
  - `out_valid`=1; `sum` and `cout` held stable.
  - On `out_ready`: go to IDLE.
- `in_ready` = (state==IDLE). It is decoded from state only, with no combinational path from `in_valid`.
- `out_valid` = (state==DONE). There is no combinational path from `out_ready`.
- Only one operation is in flight at a time. `in_valid` is ignored in RUN and DONE.
- Changes on `a`, `b`, `cin` after acceptance have no effect.
- `sum` and `cout` update only while in RUN. In IDLE they hold the last result; they are 0 after reset.
- The CLA is purely combinational; no other arithmetic path exists. The carry register is 1 bit and wraps nothing.

## Timing
- Reset values (immediate on `rst_n` low, asynchronous):
  - state=IDLE, `in_ready`=1, `out_valid`=0, `busy`=0.
  - `sum`=0, `cout`=0, idx=0, carry=0, operand registers=0.
- Reset mid-RUN or in DONE aborts the operation: no `out_valid` pulse, outputs return to the reset values.
- Latency:
  - Acceptance at edge E0.
  - Nibbles are computed on edges E1..E_NIBBLES.
  - `out_valid` rises after edge E_NIBBLES, i.e. NIBBLES cycles after acceptance (4 for WIDTH=16).
- Handshake:
  - If `out_ready` is high in the first DONE cycle, the state is IDLE after the next edge.
  - Minimum acceptance-to-acceptance spacing is therefore NIBBLES+2 cycles.
- Back-pressure: `out_valid`, `sum`, `cout` remain unchanged for as long as `out_ready` stays low.
- Full-width carry ripple (e.g. all-ones + 1) takes no extra cycles.

## Test plan
- **Reset:** assert `rst_n`=0 mid-cycle with no clock → `in_ready`=1, `out_valid`=0, `busy`=0, `sum`=0x0000, `cout`=0 immediately.
- **Basic add:** a=0x1234, b=0x4321, cin=0 with `out_ready`=1 → `out_valid` exactly 4 cycles after acceptance, `sum`=0x5555, `cout`=0, back to IDLE one cycle later.
- **Full ripple:** a=0xFFFF, b=0x0001, cin=0 → `sum`=0x0000, `cout`=1. Also a=0xD5B3, b=0x2A4C, cin=1 → `sum`=0x0000, `cout`=1.
- **Back-pressure:**
  - Hold `out_ready`=0 for 5 cycles in DONE and pulse `in_valid` with new operands → `sum`/`cout` stable, `in_ready`=0, new operands ignored.
  - After `out_ready`, the next accepted pair computes correctly.
- **Operand isolation:** after acceptance of a=0x00FF, b=0x0001, cin=0, change `a`, `b`, `cin` every cycle during RUN → `sum`=0x0100, `cout`=0.
- **Mid-RUN reset:** drop `rst_n` on the 2nd RUN cycle → `out_valid` never asserts, outputs at reset values. After release, a=0x8000, b=0x8000, cin=1 → `sum`=0x0001, `cout`=1.
